grf_scoreboard: RTL and testbench

Scoreboard and read-hazard controller for the 32x32 general register file in the pipelined MIPS core. Tracks the number of outstanding writes per architectural register between D-stage issue and W-stage writeback. Generates the D-stage stall. Provides a drain sequence that holds issue until all writes have retired, for use before reset-free context switches or exception entry.

---
 rtl/grf_sb_pkg.sv | 15 +
 rtl/sb_cnt_slot.sv | 53 +++++
 rtl/grf_scoreboard.sv | 137 +++++++++++++
 tb/tb_grf_scoreboard.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_sb_pkg.sv
// Shared constants and drain FSM encoding for the GRF scoreboard.
package grf_sb_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } sb_state_t;

endpackage

// File: rtl/sb_cnt_slot.sv
// Pending-write counter for one architectural register; saturates at both ends.
// Exposes a "last write pending" flag only when SB_WB_BYPASS_EN is defined.
module sb_cnt_slot #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic nz,
  output logic full
`ifdef SB_WB_BYPASS_EN
  ,
  output logic one
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             dec_eff;

  // A writeback against an empty counter is an error elsewhere; never underflow here.
  assign dec_eff = dec & nz;
  assign nz      = (cnt_reg != '0);
  assign full    = (cnt_reg == CNT_MAX);
`ifdef SB_WB_BYPASS_EN
  assign one     = (cnt_reg == CNT_ONE);
`endif

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && !dec_eff && !full) begin
      cnt_next = cnt_reg + CNT_ONE;
    end else if (dec_eff && !inc) begin
      cnt_next = cnt_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/grf_scoreboard.sv
// Register-file scoreboard: per-register pending writes, D-stage stall, drain FSM.
// Optional macro SB_WB_BYPASS_EN lets a reader pass in the cycle its last write retires.
module grf_scoreboard
  import grf_sb_pkg::*;
#(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs,
  input  logic [REG_AW-1:0] issue_rt,
  input  logic              issue_use_rs,
  input  logic              issue_use_rt,
  input  logic              issue_wr,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              issue_fire,
  output logic              stall,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush,
  input  logic              drain_req,
  output logic              drain_done,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [3:0]        inflight,
  output logic              sb_err
);

  localparam logic [3:0] INFL_MAX = 4'(MAX_INFLIGHT);

  logic [NUM_REGS-1:0] nz_vec;
  logic [NUM_REGS-1:0] full_vec;
`ifdef SB_WB_BYPASS_EN
  logic [NUM_REGS-1:0] one_vec;
`endif

  logic [3:0] inflight_reg, inflight_next;
  logic       sb_err_reg, sb_err_next;
  sb_state_t  state_reg, state_next;

  logic wr_fire, wb_dec, wb_under;
  logic rs_busy, rt_busy, raw_hz, cap_hz;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
      if (gi == 0) begin : g_zero
        assign nz_vec[gi]   = 1'b0;
        assign full_vec[gi] = 1'b0;
`ifdef SB_WB_BYPASS_EN
        assign one_vec[gi]  = 1'b0;
`endif
      end else begin : g_reg
        logic inc, dec;
        assign inc = wr_fire  & (issue_rd == REG_AW'(gi));
        assign dec = wb_valid & (wb_rd == REG_AW'(gi));
        sb_cnt_slot #(.CNT_W(CNT_W)) u_slot (
          .clk   (clk),
          .reset (reset),
          .clr   (flush),
          .inc   (inc),
          .dec   (dec),
          .nz    (nz_vec[gi]),
          .full  (full_vec[gi])
`ifdef SB_WB_BYPASS_EN
          ,
          .one   (one_vec[gi])
`endif
        );
      end
    end
  endgenerate

  // Source hazards; the bypass only ever relaxes reads, never capacity.
`ifdef SB_WB_BYPASS_EN
  assign rs_busy = nz_vec[issue_rs] & ~(wb_valid & (wb_rd == issue_rs) & one_vec[issue_rs]);
  assign rt_busy = nz_vec[issue_rt] & ~(wb_valid & (wb_rd == issue_rt) & one_vec[issue_rt]);
`else
  assign rs_busy = nz_vec[issue_rs];
  assign rt_busy = nz_vec[issue_rt];
`endif

  assign raw_hz = (issue_use_rs & (issue_rs != ZERO_REG) & rs_busy)
                | (issue_use_rt & (issue_rt != ZERO_REG) & rt_busy);
  assign cap_hz = issue_wr & (issue_rd != ZERO_REG)
                & (full_vec[issue_rd] | (inflight_reg == INFL_MAX));

  assign stall      = issue_valid & (raw_hz | cap_hz | (state_reg != IDLE));
  assign issue_fire = issue_valid & ~stall;

  assign wr_fire  = issue_fire & issue_wr & (issue_rd != ZERO_REG);
  assign wb_dec   = wb_valid & (wb_rd != ZERO_REG) &  nz_vec[wb_rd];
  assign wb_under = wb_valid & (wb_rd != ZERO_REG) & ~nz_vec[wb_rd];

  always_comb begin
    inflight_next = inflight_reg;
    if (flush) begin
      inflight_next = '0;
    end else if (wr_fire && !wb_dec) begin
      inflight_next = inflight_reg + 4'd1;
    end else if (wb_dec && !wr_fire) begin
      inflight_next = inflight_reg - 4'd1;
    end
  end

  // A flushed cycle's writeback is discarded, so it cannot raise the error either.
  assign sb_err_next = sb_err_reg | (wb_under & ~flush);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (drain_req) state_next = DRAIN;
      DRAIN: if (inflight_reg == 4'd0) state_next = DONE;
      DONE:  state_next = drain_req ? HOLD : IDLE;
      HOLD:  if (!drain_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg <= '0;
      sb_err_reg   <= 1'b0;
      state_reg    <= IDLE;
    end else begin
      inflight_reg <= inflight_next;
      sb_err_reg   <= sb_err_next;
      state_reg    <= state_next;
    end
  end

  assign drain_done = (state_reg == DONE);
  assign busy_vec   = nz_vec;
  assign inflight   = inflight_reg;
  assign sb_err     = sb_err_reg;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed scoreboard bench for grf_scoreboard (CNT_W=2, MAX_INFLIGHT=4).
module tb_grf_scoreboard;

  localparam int S_STALL = 0;
  localparam int S_FIRE  = 1;
  localparam int S_BUSY  = 2;
  localparam int S_INFL  = 3;
  localparam int S_ERR   = 4;
  localparam int S_DONE  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_use_rs, issue_use_rt, issue_wr;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        issue_fire, stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush, drain_req, drain_done;
  logic [31:0] busy_vec;
  logic [3:0]  inflight;
  logic        sb_err;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  grf_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_use_rs (issue_use_rs),
    .issue_use_rt (issue_use_rt),
    .issue_wr     (issue_wr),
    .issue_rd     (issue_rd),
    .issue_fire   (issue_fire),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .busy_vec     (busy_vec),
    .inflight     (inflight),
    .sb_err       (sb_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_STALL: return {31'd0, stall};
      S_FIRE:  return {31'd0, issue_fire};
      S_BUSY:  return busy_vec;
      S_INFL:  return {28'd0, inflight};
      S_ERR:   return {31'd0, sb_err};
      default: return {31'd0, drain_done};
    endcase
  endfunction

  task automatic chk(input string tag, input int sel, input logic [31:0] v);
    exp_q.push_back('{tag, sel, v});
  endtask

  // Let combinational outputs settle, then retire every queued expectation.
  task automatic settle();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.sel);
      n_tests++;
      assert (obs === e.val)
        $display("[TB] ok %s obs=%0h", e.tag, obs);
      else begin
        n_fail++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_use_rs = 0; issue_use_rt = 0; issue_wr = 0;
    issue_rs = 0; issue_rt = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; flush = 0; drain_req = 0;
  endtask

  task automatic issue_write(input logic [4:0] rd);
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = rd;
    chk($sformatf("wr_fire_rd%0d", rd), S_FIRE, 1);
    settle();
    tick();
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("rst_stall", S_STALL, 0); chk("rst_busy", S_BUSY, 0);
    chk("rst_infl", S_INFL, 0);   chk("rst_err", S_ERR, 0);
    chk("rst_done", S_DONE, 0);
    settle();

    // RAW on r8
    issue_write(5'd8);
    issue_valid = 1; issue_wr = 0; issue_use_rs = 1; issue_rs = 8;
    chk("raw_busy8", S_BUSY, 32'h100); chk("raw_infl1", S_INFL, 1);
    chk("raw_stall", S_STALL, 1);
    settle(); tick();
    chk("raw_stall_hold", S_STALL, 1);
    settle();
    wb_valid = 1; wb_rd = 8;
`ifdef SB_WB_BYPASS_EN
    chk("raw_wb_cycle", S_STALL, 0);
`else
    chk("raw_wb_cycle", S_STALL, 1);
`endif
    settle(); tick();
    wb_valid = 0;
    chk("raw_after_wb", S_STALL, 0); chk("raw_fire", S_FIRE, 1);
    chk("raw_busy0", S_BUSY, 0);     chk("raw_infl0", S_INFL, 0);
    settle(); tick();

    // r0 is never tracked
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 0;
    chk("r0_wr_stall", S_STALL, 0);
    settle(); tick();
    issue_wr = 0; issue_use_rs = 1; issue_use_rt = 1;
    chk("r0_rd_stall", S_STALL, 0); chk("r0_busy", S_BUSY, 0);
    chk("r0_infl", S_INFL, 0);
    settle(); tick();

    // Per-register saturation on r5
    for (int i = 0; i < 3; i++) issue_write(5'd5);
    issue_valid = 1; issue_wr = 1; issue_rd = 5;
    chk("sat_busy5", S_BUSY, 32'h20); chk("sat_infl3", S_INFL, 3);
    chk("sat_stall", S_STALL, 1);
    settle();
    wb_valid = 1; wb_rd = 5;
    chk("sat_stall_wb_cycle", S_STALL, 1);
    settle(); tick();
    wb_valid = 0;
    chk("sat_infl2", S_INFL, 2); chk("sat_fire", S_FIRE, 1);
    settle(); tick();
    idle();
    chk("sat_infl3_again", S_INFL, 3);
    settle();
    flush = 1;
    tick();
    flush = 0;
    chk("sat_flush_infl", S_INFL, 0); chk("sat_flush_busy", S_BUSY, 0);
    settle();

    // Global in-flight cap
    for (int r = 1; r <= 4; r++) issue_write(5'(r));
    issue_valid = 1; issue_wr = 1; issue_rd = 6;
    chk("cap_infl4", S_INFL, 4); chk("cap_stall", S_STALL, 1);
    settle();
    wb_valid = 1; wb_rd = 1;
    chk("cap_no_bypass", S_STALL, 1);
    settle(); tick();
    wb_rd = 2;
    chk("cap_infl3", S_INFL, 3); chk("cap_fire_rd6", S_FIRE, 1);
    settle(); tick();
    idle();
    chk("cap_inc_dec_infl", S_INFL, 3); chk("cap_busy", S_BUSY, 32'h58);
    settle();
    flush = 1;
    tick();
    flush = 0;

    // Underflow error, flush, reset
    wb_valid = 1; wb_rd = 9;
    chk("err_no_stall", S_STALL, 0);
    settle(); tick();
    wb_valid = 0;
    chk("err_set", S_ERR, 1);
    settle(); tick();
    chk("err_sticky", S_ERR, 1);
    settle();
    issue_write(5'd3);
    idle();
    chk("err_busy3", S_BUSY, 32'h8);
    settle();
    flush = 1; issue_valid = 1; issue_wr = 1; issue_rd = 10;
    tick();
    idle();
    chk("flush_busy", S_BUSY, 0); chk("flush_infl", S_INFL, 0);
    chk("flush_keeps_err", S_ERR, 1);
    settle();
    reset = 1;
    tick();
    reset = 0;
    chk("reset_clears_err", S_ERR, 0);
    settle();

    // Drain with two writes outstanding
    issue_write(5'd11);
    issue_write(5'd12);
    idle();
    drain_req = 1;
    chk("drn_infl2", S_INFL, 2); chk("drn_done0", S_DONE, 0);
    settle(); tick();
    issue_valid = 1; issue_use_rs = 1; issue_rs = 1;
    chk("drn_forced_stall", S_STALL, 1);
    settle();
    wb_valid = 1; wb_rd = 11;
    tick();
    wb_rd = 12;
    tick();
    wb_valid = 0;
    chk("drn_infl0", S_INFL, 0); chk("drn_not_done_yet", S_DONE, 0);
    chk("drn_stall", S_STALL, 1);
    settle(); tick();
    chk("drn_done_pulse", S_DONE, 1); chk("drn_done_stall", S_STALL, 1);
    settle(); tick();
    chk("hold_done0", S_DONE, 0); chk("hold_stall", S_STALL, 1);
    settle(); tick();
    chk("hold_stall2", S_STALL, 1);
    settle();
    drain_req = 0;
    tick();
    chk("hold_release_stall", S_STALL, 0); chk("hold_release_fire", S_FIRE, 1);
    chk("hold_release_done", S_DONE, 0);
    settle();

    // Drain with nothing outstanding: two cycles to DONE
    idle();
    drain_req = 1;
    tick();
    chk("fast_drain_c1", S_DONE, 0);
    settle(); tick();
    drain_req = 0;
    chk("fast_drain_c2", S_DONE, 1);
    settle(); tick();
    chk("fast_drain_idle", S_DONE, 0);
    settle();

    // Flush while draining
    issue_write(5'd14);
    idle();
    drain_req = 1;
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("drn_flush_infl", S_INFL, 0); chk("drn_flush_done0", S_DONE, 0);
    settle(); tick();
    chk("drn_flush_done", S_DONE, 1);
    settle();
    drain_req = 0;
    tick();

    // Reset while draining
    issue_write(5'd13);
    idle();
    drain_req = 1;
    tick();
    issue_valid = 1; issue_use_rs = 1; issue_rs = 1;
    chk("rst_drn_stall", S_STALL, 1);
    settle();
    reset = 1;
    tick();
    reset = 0; drain_req = 0;
    chk("rst_drn_stall0", S_STALL, 0); chk("rst_drn_fire", S_FIRE, 1);
    chk("rst_drn_busy", S_BUSY, 0);    chk("rst_drn_infl", S_INFL, 0);
    chk("rst_drn_done", S_DONE, 0);
    settle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
